// File: rtl/rr_priority_encoder_pkg.sv
// rtl/rr_priority_encoder_pkg.sv - shared types, mode encodings and width helper for rr_priority_encoder
package rr_priority_encoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam bit RR_MODE    = 1'b1;
    localparam bit FIXED_MODE = 1'b0;

    // Index width that never collapses to zero bits, so N=2 still gets a 1-bit index.
    function automatic int clog2_safe(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_encoder_pri_pick.sv
// rtl/rr_priority_encoder_pri_pick.sv - combinational rotate/find-first/un-rotate winner search
module pri_pick
    import rr_priority_encoder_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = clog2_safe(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   idx_sum;

    // Doubling the vector makes the rotation wrap at N rather than at 2^IDX_W.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N];
    assign any     = |req;

    // Lowest set bit of the rotated vector: scanning downward lets the lowest index win.
    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    // Undo the rotation modulo N and expand the winner to one-hot.
    always_comb begin
        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= N_EXT) begin
            idx_sum = idx_sum - N_EXT;
        end
        idx    = idx_sum[IDX_W-1:0];
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - registered round-robin / fixed-priority arbiter with ack and lock
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = clog2_safe(N),
    parameter bit RR_EN = RR_MODE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             ack,
    input  logic             lock,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             none_req
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             none_req_q;

    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W-1:0] search_ptr;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // Pointer just past the current winner; fixed priority always searches from 0.
    always_comb begin
        ptr_adv = '0;
        if (RR_EN == RR_MODE) begin
            if (idx_q == LAST_IDX) begin
                ptr_adv = '0;
            end else begin
                ptr_adv = idx_q + IDX_W'(1);
            end
        end
    end

    // While granting, the search already starts past the current winner so a
    // back-to-back re-arbitration uses the pointer value being written this cycle.
    assign search_ptr = (state_q == GRANT) ? ptr_adv : ptr_q;

    pri_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pri_pick (
        .req    (req),
        .ptr    (search_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and next-grant selection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    gnt_d   = pick_onehot;
                end
            end
            GRANT: begin
                // A locked ack keeps the winner and pointer untouched (burst).
                if (ack && !lock) begin
                    ptr_d = ptr_adv;
                    if (pick_any) begin
                        idx_d = pick_idx;
                        gnt_d = pick_onehot;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                gnt_d   = '0;
            end
        endcase
    end

    // State, pointer and grant registers; reset clears the grant without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
        end
    end

    // Registered all-quiet flag, independent of the arbitration state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            none_req_q <= 1'b1;
        end else begin
            none_req_q <= ~|req;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_idx  = idx_q;
    assign gnt_vld  = (state_q == GRANT);
    assign none_req = none_req_q;

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Parametrised, registered successor to the 8:1 combinational priority encoder.
- Accepts N request lines and selects one winner per grant cycle. Selection is either fixed priority (lowest index wins) or round-robin.
- Presents the winner as a one-hot grant plus a binary index, and holds it until the consumer acknowledges.
- Sits between request sources (DMA channels, interrupt lines) and a shared resource.

Parameters:
- N, 8, number of request inputs (2..32).
- IDX_W, $clog2(N), width of the encoded index.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, index 0 highest.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i = requester i.
- ack  input  1  consumer accepts the current grant; sampled only when gnt_vld=1.
- lock  input  1  sampled with ack; 1 = keep the same winner for the next grant (burst).
- gnt  output  N  one-hot grant; all zeros when gnt_vld=0.
- gnt_idx  output  IDX_W  binary index of the winner; 0 when gnt_vld=0.
- gnt_vld  output  1  a grant is being presented.
- none_req  output  1  registered flag: req was all-zero in the previous cycle.

Behaviour:
- Reset values: gnt=0, gnt_idx=0, gnt_vld=0, none_req=1, rotation pointer ptr=0, state=IDLE.
- Reset is asynchronous and may assert at any time, including mid-grant. On deassertion the block restarts from IDLE with ptr=0.
- FSM states:
  - IDLE: if req!=0, compute the winner and go to GRANT. gnt, gnt_idx and gnt_vld appear one cycle after req is first seen (latency 1).
  - GRANT: outputs are held stable every cycle that ack=0.
- Exits from GRANT on ack=1:
  - lock=1: stay in GRANT with the same winner. ptr is unchanged and gnt_vld stays 1.
  - lock=0 and req (masked to exclude nothing) != 0: re-arbitrate in the same cycle. The new winner is registered, so back-to-back grants have no bubble and gnt_vld stays 1.
  - lock=0 and req==0: go to IDLE. gnt_vld=0 in the next cycle.
- Winner selection in RR_EN=1:
  - Search upward from index ptr, wrapping N-1 -> 0. The first set bit wins.
  - On every non-locked ack, ptr <= winner+1, wrapping to 0 when winner=N-1.
- Winner selection in RR_EN=0:
  - ptr is held at 0, so the lowest set index always wins. This matches the legacy D0-first priority.
- A requester dropping req while granted does not revoke the grant. The grant stays until ack; the consumer is responsible for handling stale grants.
- lock is ignored unless ack=1 and gnt_vld=1. A lock held indefinitely starves the other requesters; this is by design.
- ack while gnt_vld=0 is ignored.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx always equals the encoded gnt.
  - gnt_vld equals |gnt.
- none_req is a registered ~|req, updated every cycle independent of the FSM.
- Non-power-of-two N: ptr wraps at N, not at 2^IDX_W. Index values at or above N never appear.

Decomposition:
- Shared package: typedef state_e {IDLE, GRANT}; function clog2_safe; constant RR_MODE/FIXED_MODE encodings for RR_EN.
- Sub-module: pri_pick.
  - Purely combinational.
  - Inputs: req[N], ptr[IDX_W]. Outputs: onehot[N], idx[IDX_W], any.
  - Implements the rotate -> lowest-set-bit -> un-rotate search.
  - Instantiated once; it is reusable as the fixed-priority encoder when ptr=0.
- Top level holds the FSM, ptr and output registers.

Test Plan:
- Reset/idle: rst_n=0 then 1 with req=0 for 5 cycles -> gnt_vld=0, gnt=0, gnt_idx=0, none_req=1 throughout.
- Fixed priority (RR_EN=0): req=8'b1010_0100, ack pulsed every grant -> gnt_idx=2 every grant, with gnt_vld asserted one cycle after req.
- Round-robin rotation (RR_EN=1): req=8'b1000_0101 held, ack=1 every cycle -> gnt_idx sequence 0, 2, 7, 0, 2, with no gnt_vld bubble.
- Wrap-around: ptr at 7 (after granting 6), req=8'b1000_0001 -> winner 7, then 0.
- Lock burst: ack=1 with lock=1 for 3 acks while gnt_idx=3, other reqs active -> gnt_idx stays 3. After an ack with lock=0, next winner is the first set bit from index 4.
- Hold and reset mid-grant:
  - gnt_idx=5 with ack=0 for 10 cycles, req[5] dropped at cycle 3 -> outputs stable at 5.
  - Assert rst_n=0 mid-grant -> gnt, gnt_idx and gnt_vld clear immediately without waiting for clk, and ptr=0.
